// File: rtl/count8dn_fsm_if.sv
// Control/status bundle of the loadable down-counter: the driving side supplies
// enable, load strobe and start value; the counter returns count and status flags.
interface count8dn_fsm_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic             load;
    logic [WIDTH-1:0] CNT_In;
    logic [WIDTH-1:0] CNT;
    logic             TC;
    logic             done;
    logic             busy;

    modport master (
        output EN,
        output load,
        output CNT_In,
        input  CNT,
        input  TC,
        input  done,
        input  busy
    );

    modport slave (
        input  EN,
        input  load,
        input  CNT_In,
        output CNT,
        output TC,
        output done,
        output busy
    );
endinterface

// File: rtl/count8dn_fsm.sv
// Loadable down-counter/timer as an explicit IDLE/RUN/HOLD/DONE state machine,
// with a one-cycle expiry pulse and optional auto-reload of the last start value.
module count8dn_fsm #(
    parameter int WIDTH  = 8,
    parameter bit RELOAD = 1'b0
) (
    input  logic          clk,
    input  logic          res,
    count8dn_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] rld_r;
    logic [WIDTH-1:0] rld_s;
    logic             done_r;
    logic             busy_r;

    // Next-state and next-count decode; load overrides every state and ignores EN
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rld_s   = rld_r;
        if (bus.load) begin
            cnt_s = bus.CNT_In;
            rld_s = bus.CNT_In;
            if (bus.CNT_In != ZERO) begin
                state_s = RUN;
            end else begin
                state_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN, HOLD: begin
                    if (bus.EN) begin
                        if (cnt_r > ONE) begin
                            cnt_s   = cnt_r - ONE;
                            state_s = RUN;
                        end else if (cnt_r == ONE) begin
                            cnt_s   = ZERO;
                            state_s = DONE;
                        end else begin
                            // Counting from zero is unreachable; park safely instead of wrapping
                            cnt_s   = ZERO;
                            state_s = IDLE;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                DONE: begin
                    if (RELOAD && (rld_r != ZERO)) begin
                        cnt_s   = rld_r;
                        state_s = RUN;
                    end else begin
                        cnt_s   = ZERO;
                        state_s = IDLE;
                    end
                end
                default: begin
                    cnt_s   = ZERO;
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, count, reload value and flag registers; done/busy are flopped from the next state
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r <= IDLE;
            cnt_r   <= ZERO;
            rld_r   <= ZERO;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            rld_r   <= rld_s;
            done_r  <= (state_s == DONE);
            busy_r  <= (state_s == RUN) || (state_s == HOLD);
        end
    end

    assign bus.CNT  = cnt_r;
    assign bus.TC   = (cnt_r == ZERO);
    assign bus.done = done_r;
    assign bus.busy = busy_r;

endmodule
